autobaud_ctrl: RTL and testbench

Auto-baud controller for the UART. It measures an incoming 0x55 sync character on the receive line, computes clocks-per-bit, and programs the `rate` input of the baud-rate generator. After each update it pulses a restart so the generator's tx/rx counters realign to the new rate. It sits between the pad-side `rx` line and the baud generator, under control of the UART register block.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_sync_edge.sv | 31 +++
 rtl/autobaud_ctrl.sv | 165 ++++++++++++++++
 tb/tb_autobaud_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM states, default rates and the
// rate-width derivation also used by the baud-rate generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_WAIT_EDGE,
        ST_MEASURE,
        ST_UPDATE
    } ab_state_e;

    localparam int unsigned MAX_CLOCK_RATE = 100_000_000;
    localparam int unsigned MIN_BAUD_RATE  = 9600;
    localparam int unsigned OVERSAMPLE     = 16;
    localparam int unsigned DEFAULT_RATE   = 5208;

    function automatic int rate_width(input int unsigned clk_hz, input int unsigned baud);
        return $clog2(clk_hz / baud);
    endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous rx line plus a registered
// falling-edge detector (3 clk from rx to o_fall).
module rx_sync_edge (
    input  logic clk,
    input  logic nReset,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_s1, r_s2, r_prev, r_fall;

    // Idle line is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_rx;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_fall <= r_prev & ~r_s2;
        end
    end

    assign o_rx_s = r_s2;
    assign o_fall = r_fall;

endmodule

// File: rtl/autobaud_ctrl.sv
// Auto-baud controller: times five falling edges of a 0x55 sync character and
// programs the baud generator rate. Define AUTOBAUD_CHECK_EN for per-interval checking.
module autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MaxClockRate = MAX_CLOCK_RATE,
    parameter int unsigned MinBaudRate  = MIN_BAUD_RATE,
    parameter int unsigned Oversample   = OVERSAMPLE,
    parameter int unsigned DefaultRate  = DEFAULT_RATE,
    parameter int          RateWidth    = rate_width(MaxClockRate, MinBaudRate)
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 rx,
    input  logic                 start,
    output logic [RateWidth-1:0] rate,
    output logic                 genRestartN,
    output logic                 busy,
    output logic                 locked,
    output logic                 done,
    output logic                 error
);

    localparam int                   CW       = RateWidth + 3;
    localparam logic [CW-1:0]        CNT_MAX  = '1;
    localparam logic [RateWidth-1:0] OVS      = RateWidth'(Oversample);
    localparam logic [RateWidth-1:0] DEF_RATE = RateWidth'(DefaultRate);

    ab_state_e            r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]           r_edge, w_edge_nxt;
    logic [RateWidth-1:0] r_rate, w_rate_nxt, w_cand;
    logic                 r_locked, w_locked_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_restart_n, w_restart_n_nxt;
    logic                 w_rx_s, w_fall, w_sat, w_bad;

    rx_sync_edge u_sync (
        .clk    (clk),
        .nReset (nReset),
        .i_rx   (rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    // The count seen on the 5th edge spans 8 bit periods; round to nearest.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_sat     = (w_cnt_inc == CNT_MAX);
    assign w_cand    = RateWidth'((32'(w_cnt_inc) + 32'd4) >> 3);

`ifdef AUTOBAUD_CHECK_EN
    logic [CW-1:0] r_first, r_last, w_ivl, w_dev;

    assign w_ivl = w_cnt_inc - r_last;
    assign w_dev = (w_ivl > r_first) ? w_ivl - r_first : r_first - w_ivl;
    assign w_bad = (r_edge != 2'd0) && (w_dev > (r_first >> 3));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_first <= '0;
            r_last  <= '0;
        end else if (!start && w_fall) begin
            if (r_state == ST_WAIT_EDGE) begin
                r_last <= '0;
            end else if (r_state == ST_MEASURE) begin
                r_last <= w_cnt_inc;
                if (r_edge == 2'd0) r_first <= w_cnt_inc;
            end
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_edge_nxt      = r_edge;
        w_rate_nxt      = r_rate;
        w_locked_nxt    = r_locked;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_restart_n_nxt = 1'b1;
        if (start) begin
            w_state_nxt  = ST_ARMED;
            w_cnt_nxt    = '0;
            w_edge_nxt   = '0;
            w_locked_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: ;
                ST_ARMED: if (w_rx_s) w_state_nxt = ST_WAIT_EDGE;
                ST_WAIT_EDGE: begin
                    if (w_fall) begin
                        w_cnt_nxt   = '0;
                        w_edge_nxt  = '0;
                        w_state_nxt = ST_MEASURE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_sat) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_MEASURE: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_fall && w_bad) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_fall && r_edge == 2'd3) begin
                        w_state_nxt = ST_UPDATE;
                        if (w_sat || w_cand < OVS) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_rate_nxt      = w_cand;
                            w_locked_nxt    = 1'b1;
                            w_done_nxt      = 1'b1;
                            w_restart_n_nxt = 1'b0;
                        end
                    end else if (w_sat) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_fall) begin
                        w_edge_nxt = r_edge + 2'd1;
                    end
                end
                ST_UPDATE: w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered so rate/done/genRestartN land together in UPDATE.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_edge      <= '0;
            r_rate      <= DEF_RATE;
            r_locked    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_restart_n <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_edge      <= w_edge_nxt;
            r_rate      <= w_rate_nxt;
            r_locked    <= w_locked_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_restart_n <= w_restart_n_nxt;
        end
    end

    assign rate        = r_rate;
    assign genRestartN = r_restart_n;
    assign busy        = (r_state != ST_IDLE);
    assign locked      = r_locked;
    assign done        = r_done;
    assign error       = r_err;

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Randomized bench for autobaud_ctrl: drives 0x55 frames on rx and compares
// against an edge-timing reference model. Uses a 10 MHz clock to keep timeouts short.
module tb_autobaud_ctrl;

    localparam int CLK_HZ   = 10_000_000;
    localparam int MIN_BAUD = 9600;
    localparam int OVS      = 16;
    localparam int DEF      = 520;
    localparam int RW       = $clog2(CLK_HZ / MIN_BAUD);
    localparam int CNT_MAX  = (1 << (RW + 3)) - 1;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          rx = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] rate;
    logic          genRestartN, busy, locked, done, error;

    autobaud_ctrl #(
        .MaxClockRate (CLK_HZ),
        .MinBaudRate  (MIN_BAUD),
        .Oversample   (OVS),
        .DefaultRate  (DEF)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .rx          (rx),
        .start       (start),
        .rate        (rate),
        .genRestartN (genRestartN),
        .busy        (busy),
        .locked      (locked),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int n_done, n_err, n_genlo, done_rate, done_gen, done_cyc, f5_cyc;
    int exp_rate = DEF;
    int exp_locked = 0;
    int e[11];
    int d[10];
    int lv[10];
    int f[5];

    always @(negedge clk) begin
        if (nReset) begin
            if (done) begin
                n_done++;
                done_rate = int'(rate);
                done_gen  = int'(genRestartN);
                done_cyc  = cyc;
            end
            if (error) n_err++;
            if (!genRestartN) n_genlo++;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clr_mon();
        n_done = 0; n_err = 0; n_genlo = 0;
        done_rate = -1; done_gen = -1; done_cyc = -1; f5_cyc = -1;
    endtask

    // Reference: rate is the rounded eighth of the 1st-to-5th falling-edge span.
    function automatic void model(input int fe[5], output bit ok, output int cand);
        int tot;
        tot = fe[4] - fe[0];
        ok  = 1'b1;
`ifdef AUTOBAUD_CHECK_EN
        begin
            int first, dv;
            first = fe[1] - fe[0];
            for (int i = 1; i < 4; i++) begin
                dv = (fe[i+1] - fe[i]) - first;
                if (dv < 0) dv = -dv;
                if (dv > first / 8) ok = 1'b0;
            end
        end
`endif
        cand = ((tot + 4) / 8) % (1 << RW);
        if (tot >= CNT_MAX || cand < OVS) ok = 1'b0;
    endfunction

    // Bit k ends at k*p plus per-edge jitter; bits after sbit are pushed out by samt.
    task automatic send_frame(input int p, input int jit, input int sbit, input int samt, input int nbits);
        e[0] = 0;
        for (int k = 1; k <= 10; k++) begin
            e[k] = k * p + ((k > sbit && sbit >= 0) ? samt : 0);
            if (k < 10) e[k] += int'($urandom_range(0, 2 * jit)) - jit;
        end
        for (int k = 0; k < 10; k++) begin
            d[k]  = e[k+1] - e[k];
            lv[k] = ((k % 2) == 1 || k == 9) ? 1 : 0;
        end
        for (int i = 0; i < 5; i++) f[i] = e[2*i];
        tick(8);
        for (int k = 0; k < nbits; k++) begin
            rx = lv[k][0];
            if (k == 8) f5_cyc = cyc;
            tick(d[k]);
        end
        rx = 1'b1;
        tick(20);
    endtask

    task automatic run_frame(input string tag, input int p, input int jit, input int sbit, input int samt);
        bit ok;
        int cand;
        clr_mon();
        pulse_start();
        chk({tag, "_busy_run"}, int'(busy), 1);
        send_frame(p, jit, sbit, samt, 10);
        model(f, ok, cand);
        if (ok) begin
            exp_rate   = cand;
            exp_locked = 1;
        end else begin
            exp_locked = 0;
        end
        chk({tag, "_done_cnt"}, n_done, int'(ok));
        chk({tag, "_err_cnt"}, n_err, int'(!ok));
        chk({tag, "_restart_cnt"}, n_genlo, int'(ok));
        chk({tag, "_rate"}, int'(rate), exp_rate);
        chk({tag, "_locked"}, int'(locked), exp_locked);
        chk({tag, "_busy_end"}, int'(busy), 0);
        if (ok) begin
            chk({tag, "_rate_at_done"}, done_rate, cand);
            chk({tag, "_restart_at_done"}, done_gen, 0);
            chk({tag, "_latency"}, done_cyc - f5_cyc, 4);
        end
    endtask

    initial begin
        int w;
        clr_mon();
        tick(3);
        chk("rst_rate", int'(rate), DEF);
        chk("rst_restart", int'(genRestartN), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        nReset = 1'b1;
        tick(2);

        run_frame("too_fast", 10, 0, -1, 0);
        run_frame("default", DEF, 0, -1, 0);
        run_frame("jitter", 86, 3, -1, 0);
        for (int i = 0; i < 4; i++)
            run_frame($sformatf("rnd%0d", i), int'($urandom_range(12, 600)), int'($urandom_range(0, 3)), -1, 0);

        // rx stuck low after the first edge must time out.
        clr_mon();
        pulse_start();
        tick(8);
        rx = 1'b0;
        w = 0;
        while (n_err == 0 && w < CNT_MAX + 50) begin
            tick(1);
            w++;
        end
        rx = 1'b1;
        exp_locked = 0;
        chk("timeout_err", n_err, 1);
        chk("timeout_window", int'(w >= CNT_MAX && w <= CNT_MAX + 8), 1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_done", n_done, 0);
        chk("timeout_rate", int'(rate), exp_rate);
        chk("timeout_locked", int'(locked), 0);
        tick(20);

        // Abort after the 3rd fall, then a clean frame.
        clr_mon();
        pulse_start();
        send_frame(260, 0, -1, 0, 6);
        chk("abort_busy", int'(busy), 1);
        chk("abort_done", n_done, 0);
        chk("abort_err", n_err, 0);
        run_frame("restart", 260, 0, -1, 0);

        // Reset in the middle of a frame.
        clr_mon();
        pulse_start();
        send_frame(260, 0, -1, 0, 5);
        nReset = 1'b0;
        #1;
        chk("midrst_rate", int'(rate), DEF);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_restart", int'(genRestartN), 1);
        exp_rate   = DEF;
        exp_locked = 0;
        tick(2);
        nReset = 1'b1;
        tick(2);

        run_frame("stretch", DEF, 0, 1, DEF / 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
